fir_out_requant: RTL and testbench
==================================

# fir_out_requant

Output stage placed directly downstream of the 3-tap FIR datapath. It accepts each full-precision signed product-sum (Q16.16 for DATAWIDTH=16) when the controller loads the FIR output register. It rounds and saturates the value back to the sample format (Q8.8), buffers results in a small FIFO, and presents them on a valid/ready stream. Sticky flags report saturation and dropped results.

## Interface
Parameters:
- DATAWIDTH, 16, sample width; input width is 2*DATAWIDTH
- FRAC, 8, fractional bits of the sample format (input carries 2*FRAC)
- DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  in_data is sampled on every rising edge where this is 1; no backpressure toward FIR
- in_data  in  2*DATAWIDTH  signed FIR result, Q(2*(DATAWIDTH-FRAC)).(2*FRAC)
- out_data  out  DATAWIDTH  signed requantised sample at FIFO head; 0 when empty
- out_valid  out  1  FIFO not empty
- out_ready  in  1  consumer accepts; pop on edge where out_valid & out_ready
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH (stage register excluded)
- sat_flag  out  1  sticky: some accepted input saturated
- ovf_flag  out  1  sticky: some result dropped because FIFO full
- clr_flags  in  1  synchronous clear of both sticky flags

## Operation
- Stage 1 (requant), registered:
  - r = (in_data + 2^(FRAC-1)) >>> FRAC, computed in 2*DATAWIDTH+1 bits, so there is no wrap on the add.
  - Rounding is round-half-up (toward +inf).
  - Saturation: if r > 2^(DATAWIDTH-1)-1, use 0x7FFF; if r < -2^(DATAWIDTH-1), use 0x8000. Otherwise use r[DATAWIDTH-1:0].
  - s1_data, s1_valid and s1_sat are registered on in_valid. s1_valid clears when in_valid=0.
- Stage 2 (FIFO write), when s1_valid=1:
  - Write when not full, or when full with a simultaneous pop.
  - Otherwise drop the value and set ovf_flag.
- FIFO:
  - Circular buffer; rd_ptr/wr_ptr wrap at DEPTH. Full/empty are derived from level.
  - The read is combinational from the head entry. out_data is forced to 0 when empty.
- Flags:
  - sat_flag sets when s1_valid & s1_sat, even if that value is later dropped.
  - Set has priority over clr_flags in the same cycle.
- level behaviour:
  - Push only: +1.
  - Pop only: -1.
  - Push and pop together: unchanged.
  - Pop while empty: impossible, since out_valid=0.

## Timing
- Reset: out_valid=0, out_data=0, level=0, sat_flag=0, ovf_flag=0, s1_valid=0, pointers=0. Entries in flight are discarded.
- Latency: in_valid sampled at edge N gives s1_valid after N. The FIFO write happens at N+1, and out_valid=1 with the data after N+1 (2 cycles when the FIFO was empty).
- Throughput: one input per cycle. One pop per cycle is sustained, with no bubbles when out_ready is held high.
- No empty-bypass: a push into an empty FIFO is visible only the following cycle.
- Full with push and pop on the same edge: the write succeeds, level stays DEPTH, and ovf_flag is not set.
- Pointer wrap: after DEPTH pushes/pops, ordering stays FIFO with no loss or duplication.
- rst asserted mid-stream: outputs go to reset values immediately (async). The first edge after deassertion treats the state as empty.
- out_data and out_valid change only after clock edges or rst; consumers may sample them in the same cycle as out_ready.

## Test plan
- Exact conversion: in_data=0x0001_8000 (1.5) gives out_data=0x0180 after 2 cycles. sat_flag stays 0.
- Rounding at half-LSB:
  - 0x0000_0080 gives 0x0001.
  - 0x0000_007F gives 0x0000.
  - 0xFFFF_FF80 gives 0x0000.
  - 0xFFFF_FF7F gives 0xFFFF.
- Saturation:
  - 0x0080_0000 gives 0x7FFF, and sat_flag goes to 1.
  - 0x007F_FF80 gives 0x7FFF (round pushes past the maximum).
  - 0xFF7F_0000 gives 0x8000.
  - clr_flags=1 then clears sat_flag.
- Overflow/backpressure (DEPTH=4, out_ready=0), stream inputs 1..6 (as Q16.16 integers):
  - level reaches 4 and ovf_flag goes to 1.
  - out_ready=1 then yields 1,2,3,4 in order; 5 and 6 are lost.
- Full with simultaneous push/pop: with level=4, in_valid streams continuously and out_ready=1. level stays 4, ovf_flag stays 0, and the order is preserved across more than 8 values (pointer wrap).
- Async reset mid-stream: assert rst with level=3 and s1_valid=1. Expect an immediate out_valid=0, level=0, and flags 0. No stale data appears after release.

Source files
------------

// File: rtl/fir_out_requant.sv
// Output stage after the 3-tap FIR: rounds/saturates the wide product-sum
// back to sample format, buffers results in a small FIFO, streams them out.
module fir_out_requant #(
  parameter int DATAWIDTH = 16,
  parameter int FRAC      = 8,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [2*DATAWIDTH-1:0]     in_data,
  output logic [DATAWIDTH-1:0]       out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       sat_flag,
  output logic                       ovf_flag,
  input  logic                       clr_flags
);
  localparam int IW = 2 * DATAWIDTH;
  localparam int AW = $clog2(DEPTH);
  localparam logic signed [IW:0] RND  = {{(IW+1-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
  localparam logic signed [IW:0] MAXV = {{(IW+2-DATAWIDTH){1'b0}}, {(DATAWIDTH-1){1'b1}}};
  localparam logic signed [IW:0] MINV = {{(IW+2-DATAWIDTH){1'b1}}, {(DATAWIDTH-1){1'b0}}};
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  // Stage 1: round-half-up and saturate, one guard bit so the add never wraps
  logic signed [IW:0]   sum_w, r_w;
  logic [DATAWIDTH-1:0] q_w;
  logic                 sat_w;

  always_comb begin
    sum_w = $signed({in_data[IW-1], in_data}) + RND;
    r_w   = sum_w >>> FRAC;
    sat_w = 1'b0;
    q_w   = r_w[DATAWIDTH-1:0];
    if (r_w > MAXV) begin
      sat_w = 1'b1;
      q_w   = {1'b0, {(DATAWIDTH-1){1'b1}}};
    end else if (r_w < MINV) begin
      sat_w = 1'b1;
      q_w   = {1'b1, {(DATAWIDTH-1){1'b0}}};
    end
  end

  logic                 s1_valid_q, s1_sat_q;
  logic [DATAWIDTH-1:0] s1_data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_sat_q   <= 1'b0;
      s1_data_q  <= '0;
    end else begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_sat_q  <= sat_w;
        s1_data_q <= q_w;
      end
    end
  end

  // Stage 2: FIFO; a full FIFO still accepts when the head leaves on the same edge
  logic [DATAWIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [AW:0]          level_q, level_d;
  logic                 sat_q, sat_d, ovf_q, ovf_d;
  logic                 full, empty, pop, push, drop;

  always_comb begin
    full    = (level_q == FULL_LVL);
    empty   = (level_q == '0);
    pop     = !empty && out_ready;
    push    = s1_valid_q && (!full || pop);
    drop    = s1_valid_q && full && !pop;
    level_d = level_q;
    if (push && !pop)      level_d = level_q + 1'b1;
    else if (pop && !push) level_d = level_q - 1'b1;
    sat_d = sat_q;
    ovf_d = ovf_q;
    if (clr_flags) begin
      sat_d = 1'b0;
      ovf_d = 1'b0;
    end
    if (s1_valid_q && s1_sat_q) sat_d = 1'b1;
    if (drop)                   ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= s1_data_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      sat_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
      sat_q   <= sat_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = !empty;
  assign out_data  = empty ? '0 : mem_q[rd_ptr_q];
  assign level     = level_q;
  assign sat_flag  = sat_q;
  assign ovf_flag  = ovf_q;
endmodule

// File: tb/tb_fir_out_requant.sv
// Directed bench for fir_out_requant: expected samples go into a queue,
// a negedge monitor pops and compares on every accepted output beat.
module tb_fir_out_requant;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [2:0]  level;
  logic        sat_flag, ovf_flag;
  logic        clr_flags = 1'b0;

  int checks = 0;
  int failures = 0;
  logic [15:0] exp_q[$];

  fir_out_requant #(.DATAWIDTH(16), .FRAC(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .level(level), .sat_flag(sat_flag), .ovf_flag(ovf_flag),
    .clr_flags(clr_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  task automatic send_exp(input logic [31:0] d, input logic [15:0] e);
    exp_q.push_back(e);
    send(d);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((level != 0 || exp_q.size() != 0) && n < 50) begin
      tick();
      n++;
    end
    chk({name, "_drain_timeout"}, (n < 50) ? 32'd1 : 32'd0, 32'd1);
    chk({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a beat is accepted at the next posedge when valid & ready hold here
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got %h expected none", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2;
    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_flags", {30'd0, sat_flag, ovf_flag}, 0);
    #20 rst = 1'b0;
    tick();

    // Exact conversion and two-cycle latency
    out_ready = 1'b1;
    send_exp(32'h0001_8000, 16'h0180);
    in_valid = 1'b0;
    chk("lat_n_valid", 32'(out_valid), 0);
    tick();
    chk("lat_n1_valid", 32'(out_valid), 1);
    chk("lat_n1_data", 32'(out_data), 32'h0180);
    tick();
    chk("exact_sat", 32'(sat_flag), 0);

    // Rounding at half-LSB, back to back
    send_exp(32'h0000_0080, 16'h0001);
    send_exp(32'h0000_007F, 16'h0000);
    send_exp(32'hFFFF_FF80, 16'h0000);
    send_exp(32'hFFFF_FF7F, 16'hFFFF);
    in_valid = 1'b0;
    drain("round");
    chk("round_sat", 32'(sat_flag), 0);

    // Saturation and flag clear
    send_exp(32'h0080_0000, 16'h7FFF);
    send_exp(32'h007F_FF80, 16'h7FFF);
    send_exp(32'hFF7F_0000, 16'h8000);
    in_valid = 1'b0;
    drain("sat");
    chk("sat_set", 32'(sat_flag), 1);
    chk("sat_no_ovf", 32'(ovf_flag), 0);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("sat_clr", 32'(sat_flag), 0);

    // Overflow under backpressure: 5 and 6 are lost
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      if (k <= 4) exp_q.push_back(16'(k << 8));
      send(32'(k << 16));
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("ovf_level", 32'(level), 4);
    chk("ovf_flag", 32'(ovf_flag), 1);
    chk("ovf_head", 32'(out_data), 32'h0100);
    drain("ovf");
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_clr", {30'd0, sat_flag, ovf_flag}, 0);

    // Full FIFO with push and pop on every edge, wraps pointers several times
    out_ready = 1'b0;
    for (int k = 10; k <= 13; k++) send_exp(32'(k << 16), 16'(k << 8));
    in_valid = 1'b0;
    tick();
    chk("full_level", 32'(level), 4);
    send_exp(32'(14 << 16), 16'(14 << 8));
    out_ready = 1'b1;
    for (int k = 15; k <= 26; k++) begin
      send_exp(32'(k << 16), 16'(k << 8));
      chk("full_pp_level", 32'(level), 4);
      chk("full_pp_ovf", 32'(ovf_flag), 0);
    end
    in_valid = 1'b0;
    drain("full_pp");

    // Async reset mid-stream with level=3 and a value in stage 1
    out_ready = 1'b0;
    send(32'h001E_0000);
    send(32'h001F_0000);
    send(32'h0080_0000);
    send(32'h0021_0000);
    in_valid = 1'b0;
    chk("pre_rst_level", 32'(level), 3);
    chk("pre_rst_sat", 32'(sat_flag), 1);
    #2 rst = 1'b1;
    #1;
    chk("async_valid", 32'(out_valid), 0);
    chk("async_level", 32'(level), 0);
    chk("async_data", 32'(out_data), 0);
    chk("async_flags", {30'd0, sat_flag, ovf_flag}, 0);
    #10 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("post_rst_valid", 32'(out_valid), 0);
    end
    chk("post_rst_level", 32'(level), 0);
    chk("post_rst_queue", 32'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
